// File: rtl/fpu_completion_queue.sv
// In-order completion queue for FPU results: tracks latency, presents the oldest finished entry to writeback, flags RAW hazards.
// Build option FPU_FLAGS_ACCUM_EN adds a sticky exception-flag accumulator (fflags_clr / fflags_acc).
module fpu_completion_queue #(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   issue_valid,
    output logic                   issue_ready,
    input  logic [4:0]             issue_rd,
    input  logic [2:0]             issue_latency,
    input  logic [31:0]            issue_result,
    input  logic [4:0]             issue_flags,
    output logic                   wb_valid,
    input  logic                   wb_ready,
    output logic [4:0]             wb_rd,
    output logic [31:0]            wb_result,
    output logic [4:0]             wb_flags,
    input  logic [4:0]             hz_rs1,
    input  logic [4:0]             hz_rs2,
    input  logic [4:0]             hz_rs3,
    output logic                   hazard,
    input  logic                   flush,
    output logic [$clog2(DEPTH):0] count
`ifdef FPU_FLAGS_ACCUM_EN
    ,
    input  logic                   fflags_clr,
    output logic [4:0]             fflags_acc
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DEPTH-1:0] valid_q;
    logic [4:0]       rd_q     [DEPTH];
    logic [31:0]      result_q [DEPTH];
    logic [4:0]       flags_q  [DEPTH];
    logic [2:0]       cnt_q    [DEPTH];

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic       head_done;
    logic       do_issue;
    logic       do_retire;
    logic [2:0] cnt_load;

    // Handshakes: a transfer happens only in a cycle where valid and ready are both
    // high; valid never depends on ready, and a flush cycle cancels both transfers.
    assign issue_ready = (count_q < CW'(DEPTH));
    assign head_done   = valid_q[head_q] && (cnt_q[head_q] == 3'd0);
    assign do_issue    = issue_valid && issue_ready && !flush;
    assign do_retire   = head_done && wb_ready && !flush;
    assign cnt_load    = (issue_latency == 3'd0) ? 3'd0 : issue_latency - 3'd1;

    assign wb_valid  = head_done;
    assign wb_rd     = head_done ? rd_q[head_q]     : 5'd0;
    assign wb_result = head_done ? result_q[head_q] : 32'd0;
    assign wb_flags  = head_done ? flags_q[head_q]  : 5'd0;
    assign count     = count_q;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (do_issue) begin
            tail_d = tail_q + 1'b1;
        end
        if (do_retire) begin
            head_d = head_q + 1'b1;
        end
        if (do_issue && !do_retire) begin
            count_d = count_q + 1'b1;
        end else if (!do_issue && do_retire) begin
            count_d = count_q - 1'b1;
        end
    end

    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && ((rd_q[i] == hz_rs1) || (rd_q[i] == hz_rs2) || (rd_q[i] == hz_rs3))) begin
                hazard = 1'b1;
            end
        end
    end

    // Payload fields are not reset; every consumer of them is gated by valid_q.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                if (valid_q[i] && (cnt_q[i] != 3'd0)) begin
                    cnt_q[i] <= cnt_q[i] - 3'd1;
                end
            end
            if (do_issue) begin
                valid_q[tail_q]  <= 1'b1;
                rd_q[tail_q]     <= issue_rd;
                result_q[tail_q] <= issue_result;
                flags_q[tail_q]  <= issue_flags;
                cnt_q[tail_q]    <= cnt_load;
            end
            if (do_retire) begin
                valid_q[head_q] <= 1'b0;
            end
        end
    end

`ifdef FPU_FLAGS_ACCUM_EN
    logic [4:0] fflags_acc_q, fflags_acc_d;

    // Clear takes effect first so a retiring entry's flags survive a coincident clear.
    always_comb begin
        fflags_acc_d = fflags_clr ? 5'd0 : fflags_acc_q;
        if (do_retire) begin
            fflags_acc_d = fflags_acc_d | wb_flags;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fflags_acc_q <= 5'd0;
        end else begin
            fflags_acc_q <= fflags_acc_d;
        end
    end

    assign fflags_acc = fflags_acc_q;
`endif

endmodule

// File: doc/fpu_completion_queue.md
FPU_COMPLETION_QUEUE -- requirements
Module: fpu_completion_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of in-flight entries (power of two, 2..8).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port issue_valid  input  1  execute stage presents an FPU result for tracking.
REQ-005 SHALL have port issue_ready  output  1  queue can accept an issue this cycle.
REQ-006 SHALL have port issue_rd  input  5  destination FP register.
REQ-007 SHALL have port issue_latency  input  3  FPU latency in cycles, as produced by the execute stage.
REQ-008 SHALL have port issue_result  input  32  FPU result word.
REQ-009 SHALL have port issue_flags  input  5  FPU exception flags {NV,DZ,OF,UF,NX}.
REQ-010 SHALL have port wb_valid  output  1  head entry is complete and presented to writeback.
REQ-011 SHALL have port wb_ready  input  1  writeback accepts the head entry.
REQ-012 SHALL have ports wb_rd (5), wb_result (32) and wb_flags (5), all outputs, carrying the head entry's fields.
REQ-013 SHALL have ports hz_rs1, hz_rs2 and hz_rs3, all 5-bit inputs, carrying the FP source registers of the instruction in decode.
REQ-014 SHALL have port hazard  output  1  a source register matches an in-flight rd.
REQ-015 SHALL have port flush  input  1  discard all in-flight entries.
REQ-016 SHALL have port count  output  $clog2(DEPTH)+1  number of occupied entries.

Function
REQ-017 SHALL store entries in an in-order circular buffer with head and tail pointers that wrap modulo DEPTH.
REQ-018 SHALL accept an issue when issue_valid and issue_ready are both high, writing the entry at tail.
REQ-019 SHALL drive issue_ready = (count < DEPTH); a retire in the same cycle SHALL NOT raise issue_ready.
REQ-020 SHALL load each entry's countdown with max(issue_latency,1)-1 on write.
REQ-021 SHALL decrement every valid entry's nonzero countdown each cycle, regardless of wb_ready.
REQ-022 SHALL, for an entry issued in cycle N with latency L, make it eligible no earlier than cycle N+max(L,1).
REQ-023 SHALL drive wb_valid = head valid AND head countdown == 0; younger completed entries SHALL wait for the head.
REQ-024 SHALL retire the head on wb_valid && wb_ready; wb_* SHALL hold stable while wb_valid is high and wb_ready is low.
REQ-025 SHALL update count by +1 on issue only, -1 on retire only, and leave it unchanged on simultaneous issue and retire.
REQ-026 SHALL assert hazard combinationally when any valid entry's rd equals hz_rs1, hz_rs2 or hz_rs3, with register 0 included.
REQ-027 SHALL clear all entries, pointers and count on the cycle after flush is high, and SHALL drop any issue or retire in that cycle.
REQ-028 SHALL drive wb_rd, wb_result and wb_flags to 0 whenever wb_valid is low.

Reset
REQ-029 SHALL, on rst, clear all valid bits, head, tail and count to 0 and force wb_valid=0, wb_*=0, hazard=0 and issue_ready=1.
REQ-030 SHALL treat rst mid-operation as a flush: in-flight entries are lost and no wb_valid follows.
REQ-031 SHALL give rst priority over flush, issue and retire in the same cycle.

Configuration
REQ-032 SHALL, with macro FPU_FLAGS_ACCUM_EN defined, add input fflags_clr (1) and output fflags_acc (5).
REQ-033 SHALL, with FPU_FLAGS_ACCUM_EN defined, OR wb_flags into fflags_acc on each retire and clear it on rst or fflags_clr.
REQ-034 SHALL, with FPU_FLAGS_ACCUM_EN defined, apply fflags_clr before the OR when fflags_clr coincides with a retire.
REQ-035 SHALL, without FPU_FLAGS_ACCUM_EN defined, omit fflags_clr, fflags_acc and the sticky register entirely.

Verification
REQ-036 SHALL cover: issue rd=3, L=4, result=0x3F800000, wb_ready=1 at cycle 0 -> wb_valid first high at cycle 4 with wb_rd=3 and wb_result=0x3F800000.
REQ-037 SHALL cover: issue A (L=5) at cycle 0 then B (L=1) at cycle 1 -> A retires at cycle 5 and B at cycle 6, in order.
REQ-038 SHALL cover: 4 issues with wb_ready=0 -> count=4, issue_ready=0; a 5th issue is ignored; raising wb_ready drains all 4 entries in order.
REQ-039 SHALL cover: in-flight rd=7 with hz_rs2=7 -> hazard=1; after that entry retires, hazard=0.
REQ-040 SHALL cover: flush asserted with 3 in-flight entries and a simultaneous issue -> next cycle count=0, wb_valid=0 and no retire occurs.
REQ-041 SHALL cover, with FPU_FLAGS_ACCUM_EN defined: retire flags 0x01 then 0x10 -> fflags_acc=0x11; pulse fflags_clr -> fflags_acc=0x00.
